// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states and parity modes.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StPar,
        StStop
    } uart_state_e;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    // Mismatch between the received parity bit and the parity implied by the data.
    function automatic logic parity_mismatch(input logic data_xor, input logic par_bit,
                                             input int unsigned mode);
        logic err;
        err = 1'b0;
        if (mode == PARITY_EVEN) begin
            err = data_xor ^ par_bit;
        end else if (mode == PARITY_ODD) begin
            err = ~(data_xor ^ par_bit);
        end
        return err;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Down-counting bit timer: loads a half- or full-bit period and flags expiry with tick.
module uart_bit_timer #(
    parameter int unsigned CLK_PER_BIT = 868,
    parameter int unsigned HALF_BIT    = 434,
    parameter int unsigned CNT_WIDTH   = 14
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic sel_half,
    output logic tick
);

    localparam logic [CNT_WIDTH-1:0] HALF_RELOAD = CNT_WIDTH'(HALF_BIT - 1);
    localparam logic [CNT_WIDTH-1:0] FULL_RELOAD = CNT_WIDTH'(CLK_PER_BIT - 1);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Counter parks at zero instead of wrapping; the FSM reloads it at each sample.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = sel_half ? HALF_RELOAD : FULL_RELOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/uart_rx_engine.sv
// UART receiver: synchronizer, framing FSM, one-word output buffer with error flags.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = 868,
    parameter int unsigned HALF_BIT    = 434,
    parameter int unsigned CNT_WIDTH   = 14,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY      = 0,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun,
    output logic                 busy
);

    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    logic       sync1_q, sync2_q, prev_q;
    logic [1:0] settle_q;
    logic       rx_s, fall;

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 par_bit_q, par_bit_d;
    logic                 stop_err_q, stop_err_d;
    logic                 timer_load, timer_half, tick, frame_done;

    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 par_err_q, par_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 break_q, break_d;
    logic                 overrun_q, overrun_d;
    logic                 par_err_new, break_new;

    // prev_q only reports a high line once the synchronizer has flushed its reset
    // value, so a line held low through reset never looks like a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            settle_q <= 2'b00;
            prev_q   <= 1'b0;
        end else begin
            sync1_q  <= uart_rx;
            sync2_q  <= sync1_q;
            settle_q <= {settle_q[0], 1'b1};
            prev_q   <= sync2_q & settle_q[1];
        end
    end

    assign rx_s = sync2_q;
    assign fall = prev_q & ~rx_s;

    uart_bit_timer #(
        .CLK_PER_BIT (CLK_PER_BIT),
        .HALF_BIT    (HALF_BIT),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .sel_half (timer_half),
        .tick     (tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        par_bit_d  = par_bit_q;
        stop_err_d = stop_err_q;
        timer_load = 1'b0;
        timer_half = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fall) begin
                    timer_load = 1'b1;
                    timer_half = 1'b1;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    stop_err_d = 1'b0;
                    state_d    = StStart;
                end
            end
            StStart: begin
                if (tick) begin
                    if (!rx_s) begin
                        timer_load = 1'b1;
                        state_d    = StData;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                    timer_load = 1'b1;
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = (PARITY != PARITY_NONE) ? StPar : StStop;
                    end
                end
            end
            StPar: begin
                if (tick) begin
                    par_bit_d  = rx_s;
                    timer_load = 1'b1;
                    state_d    = StStop;
                end
            end
            StStop: begin
                if (tick) begin
                    stop_err_d = stop_err_q | ~rx_s;
                    // Leave on the last sample rather than waiting out the stop bit.
                    if (stop_cnt_q == LAST_STOP) begin
                        frame_done = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        timer_load = 1'b1;
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_bit_q  <= 1'b0;
            stop_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            par_bit_q  <= par_bit_d;
            stop_err_q <= stop_err_d;
        end
    end

    assign par_err_new = parity_mismatch(^shift_q, par_bit_q, PARITY);
    assign break_new   = (shift_q == '0) && ((PARITY == PARITY_NONE) || !par_bit_q) && stop_err_d;

    // A pending unaccepted word wins over a newly completed one.
    always_comb begin
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        par_err_d   = par_err_q;
        frame_err_d = frame_err_q;
        break_d     = break_q;
        overrun_d   = 1'b0;
        if (frame_done) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d   = shift_q;
                rx_valid_d  = 1'b1;
                par_err_d   = par_err_new;
                frame_err_d = stop_err_d;
                break_d     = break_new;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            break_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            par_err_q   <= par_err_d;
            frame_err_q <= frame_err_d;
            break_q     <= break_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = par_err_q;
    assign frame_err  = frame_err_q;
    assign break_det  = break_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine: an 8N1 and an 8E1 instance at 16 clocks per bit.
module tb_uart_rx_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_n, rx_e, rdy_n, rdy_e;
    logic [7:0] data_n, data_e;
    logic       valid_n, valid_e, perr_n, perr_e, ferr_n, ferr_e;
    logic       brk_n, brk_e, ovr_n, ovr_e, busy_n, busy_e;

    always #5 clk = ~clk;

    uart_rx_engine #(
        .CLK_PER_BIT (16), .HALF_BIT (8), .CNT_WIDTH (5),
        .DATA_BITS (8), .PARITY (0), .STOP_BITS (1)
    ) dut_n (
        .clk (clk), .reset (reset), .uart_rx (rx_n), .rx_data (data_n),
        .rx_valid (valid_n), .rx_ready (rdy_n), .parity_err (perr_n),
        .frame_err (ferr_n), .break_det (brk_n), .overrun (ovr_n), .busy (busy_n)
    );

    uart_rx_engine #(
        .CLK_PER_BIT (16), .HALF_BIT (8), .CNT_WIDTH (5),
        .DATA_BITS (8), .PARITY (1), .STOP_BITS (1)
    ) dut_e (
        .clk (clk), .reset (reset), .uart_rx (rx_e), .rx_data (data_e),
        .rx_valid (valid_e), .rx_ready (rdy_e), .parity_err (perr_e),
        .frame_err (ferr_e), .break_det (brk_e), .overrun (ovr_e), .busy (busy_e)
    );

    // sel picks which instance the logging below observes: 0 = 8N1, 1 = 8E1.
    bit         sel = 1'b0;
    logic [7:0] s_data;
    logic       s_valid, s_perr, s_ferr, s_brk, s_ovr, s_busy;
    assign s_data  = sel ? data_e  : data_n;
    assign s_valid = sel ? valid_e : valid_n;
    assign s_perr  = sel ? perr_e  : perr_n;
    assign s_ferr  = sel ? ferr_e  : ferr_n;
    assign s_brk   = sel ? brk_e   : brk_n;
    assign s_ovr   = sel ? ovr_e   : ovr_n;
    assign s_busy  = sel ? busy_e  : busy_n;

    logic [7:0] log_data  [0:511];
    logic       log_valid [0:511];
    logic       log_perr  [0:511];
    logic       log_ferr  [0:511];
    logic       log_brk   [0:511];
    logic       log_ovr   [0:511];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic drive(input bit which, input logic v);
        if (which) rx_e = v;
        else       rx_n = v;
    endtask

    task automatic set_ready(input bit which, input logic v);
        if (which) rdy_e = v;
        else       rdy_n = v;
    endtask

    // Line bit k occupies cycles [16k, 16k+16) after the call; entered just after an edge.
    task automatic run_line(input logic [63:0] bits, input int nbits, input bit which,
                            input int ncyc);
        sel = which;
        drive(which, bits[0]);
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            log_data[c]  = s_data;
            log_valid[c] = s_valid;
            log_perr[c]  = s_perr;
            log_ferr[c]  = s_ferr;
            log_brk[c]   = s_brk;
            log_ovr[c]   = s_ovr;
            drive(which, ((c / 16) < nbits) ? bits[c / 16] : 1'b1);
        end
        drive(which, 1'b1);
    endtask

    task automatic consume(input bit which, input string name);
        sel = which;
        set_ready(which, 1'b1);
        @(posedge clk);
        #1;
        check({name, " valid cleared after accept"}, 32'(s_valid), 32'd0);
        set_ready(which, 1'b0);
    endtask

    function automatic logic [63:0] make_frame(input logic [7:0] d, input bit has_par,
                                               input logic par, input logic stop);
        logic [63:0] b;
        b    = '1;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[1 + i] = d[i];
        if (has_par) begin
            b[9]  = par;
            b[10] = stop;
        end else begin
            b[9] = stop;
        end
        return b;
    endfunction

    typedef struct {
        string      name;
        logic [7:0] data;
        bit         has_par;
        logic       par;
        logic       stop;
        logic       exp_perr;
        logic       exp_ferr;
        logic       exp_brk;
    } vec_t;

    vec_t vecs [7];

    // Edge (cycles after start bit begins) at which rx_valid first reads high.
    function automatic int stop_edge(input bit has_par);
        return 27 + 16 * (8 + (has_par ? 1 : 0));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] b;
        logic [63:0] b2;
        int          se;
        int          novr;
        int          act;

        vecs[0] = '{"8N1 A5",        8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{"8E1 07 badpar", 8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{"8N1 break",     8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{"8E1 3C okpar",  8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{"8N1 FF badstop",8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{"8E1 break",     8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{"8E1 00 par1",   8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        reset = 1'b1;
        rx_n  = 1'b1;
        rx_e  = 1'b1;
        rdy_n = 1'b0;
        rdy_e = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset valid",    32'(valid_n), 32'd0);
        check("reset data",     32'(data_n),  32'd0);
        check("reset busy",     32'(busy_n),  32'd0);
        check("reset flags",    32'({perr_n, ferr_n, brk_n, ovr_n}), 32'd0);
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            se = stop_edge(vecs[i].has_par);
            b  = make_frame(vecs[i].data, vecs[i].has_par, vecs[i].par, vecs[i].stop);
            run_line(b, vecs[i].has_par ? 11 : 10, vecs[i].has_par,
                     16 * (vecs[i].has_par ? 11 : 10) + 8);
            check({vecs[i].name, " valid before"}, 32'(log_valid[se - 1]), 32'd0);
            check({vecs[i].name, " valid"},        32'(log_valid[se]),     32'd1);
            check({vecs[i].name, " data"},         32'(log_data[se]),      32'(vecs[i].data));
            check({vecs[i].name, " parity_err"},   32'(log_perr[se]),      32'(vecs[i].exp_perr));
            check({vecs[i].name, " frame_err"},    32'(log_ferr[se]),      32'(vecs[i].exp_ferr));
            check({vecs[i].name, " break_det"},    32'(log_brk[se]),       32'(vecs[i].exp_brk));
            check({vecs[i].name, " overrun"},      32'(log_ovr[se]),       32'd0);
            consume(vecs[i].has_par, vecs[i].name);
        end

        // Four-cycle low glitch: start qualifies, half-bit sample sees high, back to idle.
        sel  = 1'b0;
        rx_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx_n = 1'b1;
        act  = 0;
        for (int c = 5; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (c == 5)  check("glitch busy during start", 32'(busy_n), 32'd1);
            if (c == 14) check("glitch busy after 10",     32'(busy_n), 32'd0);
            act += int'(valid_n);
        end
        check("glitch no valid", 32'(act), 32'd0);

        // Back-to-back frames with no consumer: second word is dropped with one overrun pulse.
        b  = make_frame(8'h11, 1'b0, 1'b0, 1'b1);
        b2 = make_frame(8'h22, 1'b0, 1'b0, 1'b1);
        run_line({b2[53:0], b[9:0]}, 20, 1'b0, 330);
        novr = 0;
        for (int c = 1; c <= 330; c++) novr += int'(log_ovr[c]);
        check("ovr first valid",   32'(log_valid[155]), 32'd1);
        check("ovr first data",    32'(log_data[155]),  32'h11);
        check("ovr pulse",         32'(log_ovr[315]),   32'd1);
        check("ovr pulse ends",    32'(log_ovr[316]),   32'd0);
        check("ovr pulse count",   32'(novr),           32'd1);
        check("ovr data kept",     32'(log_data[330]),  32'h11);
        check("ovr valid kept",    32'(log_valid[330]), 32'd1);
        consume(1'b0, "ovr");

        // Leave a word pending, then reset mid-frame with the line low.
        run_line(make_frame(8'h5A, 1'b0, 1'b0, 1'b1), 10, 1'b0, 168);
        check("pre-reset word valid", 32'(log_valid[168]), 32'd1);
        b    = make_frame(8'h07, 1'b0, 1'b0, 1'b1);
        rx_n = b[0];
        for (int c = 1; c <= 70; c++) begin
            @(posedge clk);
            #1;
            rx_n = b[c / 16];
        end
        check("midframe busy",  32'(busy_n), 32'd1);
        check("midframe line",  32'(rx_n),   32'd0);
        reset = 1'b1;
        #2;
        check("async reset valid", 32'(valid_n), 32'd0);
        check("async reset data",  32'(data_n),  32'd0);
        check("async reset busy",  32'(busy_n),  32'd0);
        check("async reset flags", 32'({perr_n, ferr_n, brk_n, ovr_n}), 32'd0);
        rx_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        act   = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            act += int'(busy_n) + int'(valid_n);
        end
        check("low line no start", 32'(act), 32'd0);
        rx_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        run_line(make_frame(8'h3C, 1'b0, 1'b0, 1'b1), 10, 1'b0, 168);
        check("post-reset valid before", 32'(log_valid[154]), 32'd0);
        check("post-reset valid",        32'(log_valid[155]), 32'd1);
        check("post-reset data",         32'(log_data[155]),  32'h3C);
        consume(1'b0, "post-reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
